// File: rtl/dma_mc.sv
// Multi-channel descriptor-chained DMA: CSR slave port plus one shared read/write
// master; channels are served round-robin, one descriptor per grant.
module dma_mc #(
    parameter int NCH    = 2,
    parameter int DATA_W = 32,
    parameter int CSR_AW = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              DMA_interrupt,
    output logic              R_req,
    output logic [31:0]       AR_ADDR,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic              R_valid,
    output logic              W_req,
    output logic [31:0]       AW_ADDR,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              W_done,
    input  logic              CEB,
    input  logic              WEB,
    input  logic [CSR_AW-1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO
);
    localparam int          CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [31:0] STEP  = 32'(DATA_W / 8);
    localparam logic [31:0] AMASK = 32'(DATA_W / 8 - 1);

    typedef enum logic [2:0] {IDLE, ARB, DFETCH, CHECK, XRD, XWR, NEXTD} state_t;
    state_t state;

    logic [NCH-1:0]       en, ie, busy, done, err;
    logic [NCH-1:0][31:0] desc_base, ptr, bytes;
    logic [CW-1:0]        cur, last, grant;
    logic                 any_busy;
    logic [1:0]           fidx;
    logic [31:0]          d_src, d_dst, d_len, d_next, off;

    logic [CSR_AW-1:0] ch_sel;
    logic [1:0]        rsel;
    logic [31:0]       rd_val;

    assign ch_sel = A >> 2;
    assign rsel   = A[1:0];

    // first busy channel after the last-served one
    always_comb begin
        logic [CW-1:0] idx;
        idx      = '0;
        grant    = last;
        any_busy = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            idx = CW'((int'(last) + i) % NCH);
            if (busy[idx]) begin
                grant    = idx;
                any_busy = 1'b1;
            end
        end
    end

    // channels >= NCH never match, so they read as 0
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(ch_sel) == c) begin
                case (rsel)
                    2'd0:    rd_val = {30'b0, ie[c], en[c]};
                    2'd1:    rd_val = desc_base[c];
                    2'd2:    rd_val = {29'b0, err[c], done[c], busy[c]};
                    default: rd_val = bytes[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            en            <= '0;
            ie            <= '0;
            busy          <= '0;
            done          <= '0;
            err           <= '0;
            desc_base     <= '0;
            ptr           <= '0;
            bytes         <= '0;
            cur           <= '0;
            last          <= CW'(NCH - 1);
            fidx          <= '0;
            d_src         <= '0;
            d_dst         <= '0;
            d_len         <= '0;
            d_next        <= '0;
            off           <= '0;
            R_req         <= 1'b0;
            AR_ADDR       <= '0;
            W_req         <= 1'b0;
            AW_ADDR       <= '0;
            W_DATA        <= '0;
            DO            <= '0;
            DMA_interrupt <= 1'b0;
        end else begin
            if (!CEB && WEB)
                DO <= rd_val;
            DMA_interrupt <= |((done | err) & ie);

            // software first: hardware updates below take precedence on conflict
            for (int c = 0; c < NCH; c++) begin
                if (!CEB && !WEB && int'(ch_sel) == c) begin
                    case (rsel)
                        2'd0: begin
                            en[c] <= DI[0];
                            ie[c] <= DI[1];
                            if (DI[0] && !en[c] && !busy[c]) begin
                                busy[c]  <= 1'b1;
                                ptr[c]   <= desc_base[c];
                                bytes[c] <= '0;
                            end
                        end
                        2'd1: desc_base[c] <= DI;
                        2'd2: begin
                            if (DI[1]) done[c] <= 1'b0;
                            if (DI[2]) err[c]  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            case (state)
                IDLE: if (any_busy) state <= ARB;
                ARB: begin
                    if (!any_busy) begin
                        state <= IDLE;
                    end else if (!en[grant]) begin
                        busy[grant] <= 1'b0;
                        last        <= grant;
                    end else begin
                        cur     <= grant;
                        last    <= grant;
                        fidx    <= '0;
                        off     <= '0;
                        R_req   <= 1'b1;
                        AR_ADDR <= ptr[grant];
                        state   <= DFETCH;
                    end
                end
                DFETCH: begin
                    if (R_req && R_valid) begin
                        R_req <= 1'b0;
                        case (fidx)
                            2'd0:    d_src  <= R_DATA[31:0];
                            2'd1:    d_dst  <= R_DATA[31:0];
                            2'd2:    d_len  <= R_DATA[31:0];
                            default: d_next <= R_DATA[31:0];
                        endcase
                        fidx <= fidx + 2'd1;
                        if (fidx == 2'd3) state <= CHECK;
                    end else if (!R_req) begin
                        R_req   <= 1'b1;
                        AR_ADDR <= ptr[cur] + {28'b0, fidx, 2'b00};
                    end
                end
                CHECK: begin
                    if (!en[cur]) begin
                        busy[cur] <= 1'b0;
                        state     <= ARB;
                    end else if (((d_src | d_dst | d_len) & AMASK) != '0) begin
                        err[cur]  <= 1'b1;
                        en[cur]   <= 1'b0;
                        busy[cur] <= 1'b0;
                        state     <= ARB;
                    end else if (d_len == '0) begin
                        state <= NEXTD;
                    end else begin
                        state <= XRD;
                    end
                end
                XRD: begin
                    if (R_req && R_valid) begin
                        R_req  <= 1'b0;
                        W_DATA <= R_DATA;
                        if (!en[cur]) begin
                            busy[cur] <= 1'b0;
                            state     <= ARB;
                        end else begin
                            state <= XWR;
                        end
                    end else if (!R_req) begin
                        if (!en[cur]) begin
                            busy[cur] <= 1'b0;
                            state     <= ARB;
                        end else begin
                            R_req   <= 1'b1;
                            AR_ADDR <= d_src + off;
                        end
                    end
                end
                XWR: begin
                    if (W_req && W_done) begin
                        W_req      <= 1'b0;
                        off        <= off + STEP;
                        bytes[cur] <= bytes[cur] + STEP;
                        if (!en[cur]) begin
                            busy[cur] <= 1'b0;
                            state     <= ARB;
                        end else if (off + STEP == d_len) begin
                            state <= NEXTD;
                        end else begin
                            state <= XRD;
                        end
                    end else if (!W_req) begin
                        W_req   <= 1'b1;
                        AW_ADDR <= d_dst + off;
                    end
                end
                NEXTD: begin
                    if (d_next[0]) begin
                        done[cur] <= 1'b1;
                        en[cur]   <= 1'b0;
                        busy[cur] <= 1'b0;
                    end else begin
                        ptr[cur] <= d_next & 32'hFFFF_FFFC;
                    end
                    state <= ARB;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_mc.sv
// Bench for dma_mc: behavioural memory with adjustable latency, write-beat and
// descriptor-fetch scoreboards, CSR readback of status/byte counters.
module tb_dma_mc;
    localparam int NCH    = 2;
    localparam int DATA_W = 32;
    localparam int CSR_AW = 3;

    logic              clk, rst;
    logic              DMA_interrupt, R_req, R_valid, W_req, W_done;
    logic [31:0]       AR_ADDR, AW_ADDR, DI, DO;
    logic [DATA_W-1:0] R_DATA, W_DATA;
    logic              CEB, WEB;
    logic [CSR_AW-1:0] A;

    dma_mc #(.NCH(NCH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .DMA_interrupt(DMA_interrupt),
        .R_req(R_req), .AR_ADDR(AR_ADDR), .R_DATA(R_DATA), .R_valid(R_valid),
        .W_req(W_req), .AW_ADDR(AW_ADDR), .W_DATA(W_DATA), .W_done(W_done),
        .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int lat = 1;
    int wbeats = 0, n_extra = 0, n_overlap = 0, n_unstable = 0;
    logic [31:0] mem [logic [31:0]];
    logic [63:0] wq[$];   // expected {addr, data} per write beat
    logic [31:0] fq[$];   // expected descriptor fetch order

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // memory slave: descriptors live at >= 0x8000, data below
    initial begin
        int rcnt, wcnt;
        logic [31:0] ra0, wa0;
        logic [63:0] e;
        rcnt = 0; wcnt = 0; ra0 = '0; wa0 = '0;
        R_valid = 1'b0; W_done = 1'b0; R_DATA = '0;
        forever begin
            @(negedge clk);
            R_valid = 1'b0;
            W_done  = 1'b0;
            if (R_req && W_req) n_overlap++;
            if (R_req) begin
                if (rcnt == 0) ra0 = AR_ADDR;
                else if (AR_ADDR !== ra0) n_unstable++;
                rcnt++;
                if (rcnt >= lat) begin
                    R_valid = 1'b1;
                    R_DATA  = mem_rd(AR_ADDR);
                    rcnt    = 0;
                    if (AR_ADDR >= 32'h8000 && AR_ADDR[3:0] == 4'h0) begin
                        if (fq.size() > 0) chk("fetch_order", AR_ADDR, fq.pop_front());
                        else n_extra++;
                    end
                end
            end else rcnt = 0;
            if (W_req) begin
                if (wcnt == 0) wa0 = AW_ADDR;
                else if (AW_ADDR !== wa0) n_unstable++;
                wcnt++;
                if (wcnt >= lat) begin
                    W_done = 1'b1;
                    wcnt   = 0;
                    mem[AW_ADDR] = W_DATA;
                    wbeats++;
                    if (wq.size() > 0) begin
                        e = wq.pop_front();
                        chk("wr_addr", AW_ADDR, e[63:32]);
                        chk("wr_data", W_DATA, e[31:0]);
                    end else n_extra++;
                end
            end else wcnt = 0;
        end
    end

    task automatic csr_wr(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        CEB = 1'b0; WEB = 1'b0; A = CSR_AW'(ch * 4 + r); DI = d;
        @(negedge clk);
        CEB = 1'b1; WEB = 1'b1;
    endtask

    task automatic csr_rd(input int ch, input int r, output logic [31:0] d);
        @(negedge clk);
        CEB = 1'b0; WEB = 1'b1; A = CSR_AW'(ch * 4 + r);
        @(negedge clk);
        CEB = 1'b1;
        d = DO;
    endtask

    // descriptor plus random source data; the first npush beats are expected writes
    task automatic add_desc(input logic [31:0] da, src, dst, len, nxt, input int npush);
        logic [31:0] d;
        mem[da] = src; mem[da + 4] = dst; mem[da + 8] = len; mem[da + 12] = nxt;
        for (int i = 0; i < int'(len) / 4; i++) begin
            d = $urandom;
            mem[src + 32'(4 * i)] = d;
            if (i < npush) wq.push_back({dst + 32'(4 * i), d});
        end
    endtask

    task automatic wait_idle(input int ch);
        logic [31:0] s;
        int k;
        k = 0;
        do begin
            csr_rd(ch, 2, s);
            k++;
        end while (s[0] && k < 2000);
        chk("idle_wait", {31'b0, s[0]}, 32'h0);
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (wbeats < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("beat_wait", wbeats, 32'(n));
    endtask

    initial begin
        logic [31:0] d;
        int k, wb0;
        CEB = 1'b1; WEB = 1'b1; A = '0; DI = '0; rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rreq", R_req, 0);
        chk("rst_wreq", W_req, 0);
        chk("rst_irq", DMA_interrupt, 0);
        chk("rst_do", DO, 0);
        rst = 1'b1;
        csr_rd(0, 2, d); chk("rst_status0", d, 0);
        csr_rd(1, 0, d); chk("rst_ctrl1", d, 0);

        // single descriptor on channel 0
        lat = 1; wb0 = wbeats;
        add_desc(32'h8000, 32'h1000, 32'h2000, 16, 32'h1, 4);
        fq.push_back(32'h8000);
        csr_wr(0, 1, 32'h8000);
        csr_wr(0, 0, 32'h3);
        k = 0;
        while (!R_req && k < 10) begin @(negedge clk); k++; end
        chk("start_latency_le3", {31'b0, (k + 1) <= 3}, 32'h1);
        wait_idle(0);
        chk("t1_beats", wbeats - wb0, 4);
        csr_rd(0, 3, d); chk("t1_bytes", d, 16);
        csr_rd(0, 2, d); chk("t1_status", d, 32'h2);
        csr_rd(0, 0, d); chk("t1_ctrl", d, 32'h2);
        chk("t1_irq", DMA_interrupt, 1);
        chk("t1_mem_last", mem_rd(32'h200C), mem_rd(32'h100C));
        csr_wr(0, 2, 32'h2);
        @(negedge clk);
        chk("t1_irq_clr", DMA_interrupt, 0);

        // two-link chain
        wb0 = wbeats;
        add_desc(32'h8040, 32'h1100, 32'h2100, 8, 32'h8080, 2);
        add_desc(32'h8080, 32'h1200, 32'h2200, 4, 32'h1, 1);
        fq.push_back(32'h8040); fq.push_back(32'h8080);
        csr_wr(0, 1, 32'h8040);
        csr_wr(0, 0, 32'h3);
        wait_beats(wb0 + 2);
        csr_rd(0, 2, d); chk("t2_mid_status", d, 32'h1);
        wait_idle(0);
        csr_rd(0, 3, d); chk("t2_bytes", d, 12);
        csr_rd(0, 2, d); chk("t2_status", d, 32'h2);

        // two channels, two descriptors each, from a fresh reset
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        lat = 2; wb0 = wbeats;
        add_desc(32'h8100, 32'h1300, 32'h2300, 8,  32'h8140, 2);
        add_desc(32'h8180, 32'h1500, 32'h2500, 12, 32'h81C0, 3);
        add_desc(32'h8140, 32'h1400, 32'h2400, 4,  32'h1, 1);
        add_desc(32'h81C0, 32'h1600, 32'h2600, 8,  32'h1, 2);
        fq.push_back(32'h8100); fq.push_back(32'h8180);
        fq.push_back(32'h8140); fq.push_back(32'h81C0);
        csr_wr(0, 1, 32'h8100);
        csr_wr(1, 1, 32'h8180);
        csr_wr(0, 0, 32'h3);
        csr_wr(1, 0, 32'h3);
        wait_idle(0);
        wait_idle(1);
        chk("t3_beats", wbeats - wb0, 8);
        csr_rd(0, 3, d); chk("t3_bytes0", d, 12);
        csr_rd(1, 3, d); chk("t3_bytes1", d, 20);
        csr_rd(0, 2, d); chk("t3_status0", d, 32'h2);
        csr_rd(1, 2, d); chk("t3_status1", d, 32'h2);
        chk("t3_irq", DMA_interrupt, 1);
        csr_wr(0, 2, 32'h6);
        csr_wr(1, 2, 32'h6);
        @(negedge clk);
        chk("t3_irq_clr", DMA_interrupt, 0);

        // misaligned length -> error, no data beats
        lat = 1; wb0 = wbeats;
        add_desc(32'h8200, 32'h1700, 32'h2700, 6, 32'h1, 0);
        fq.push_back(32'h8200);
        csr_wr(1, 1, 32'h8200);
        csr_wr(1, 0, 32'h3);
        wait_idle(1);
        chk("t4_beats", wbeats - wb0, 0);
        csr_rd(1, 2, d); chk("t4_status", d, 32'h4);
        csr_rd(1, 0, d); chk("t4_ctrl", d, 32'h2);
        chk("t4_irq", DMA_interrupt, 1);
        csr_wr(1, 2, 32'h4);
        @(negedge clk);
        chk("t4_irq_clr", DMA_interrupt, 0);

        // zero-length end-of-chain descriptor, interrupt masked
        wb0 = wbeats;
        add_desc(32'h8240, 32'h1800, 32'h2800, 0, 32'h1, 0);
        fq.push_back(32'h8240);
        csr_wr(0, 1, 32'h8240);
        csr_wr(0, 0, 32'h1);
        wait_idle(0);
        chk("t5_beats", wbeats - wb0, 0);
        csr_rd(0, 3, d); chk("t5_bytes", d, 0);
        csr_rd(0, 2, d); chk("t5_status", d, 32'h2);
        chk("t5_irq_masked", DMA_interrupt, 0);
        csr_wr(0, 2, 32'h2);

        // abort after the second write beat
        lat = 3; wb0 = wbeats;
        add_desc(32'h8280, 32'h1900, 32'h2900, 32, 32'h1, 2);
        fq.push_back(32'h8280);
        csr_wr(0, 1, 32'h8280);
        csr_wr(0, 0, 32'h1);
        wait_beats(wb0 + 2);
        csr_wr(0, 0, 32'h0);
        wait_idle(0);
        repeat (10) @(negedge clk);
        chk("t6_beats", wbeats - wb0, 2);
        csr_rd(0, 3, d); chk("t6_bytes", d, 8);
        csr_rd(0, 2, d); chk("t6_status", d, 32'h0);

        // reset during a data read
        lat = 4;
        add_desc(32'h82C0, 32'h1A00, 32'h2A00, 16, 32'h1, 0);
        fq.push_back(32'h82C0);
        csr_wr(0, 1, 32'h82C0);
        csr_wr(0, 0, 32'h3);
        k = 0;
        while (!(R_req && AR_ADDR == 32'h1A00) && k < 300) begin @(negedge clk); k++; end
        chk("t7_xrd_reached", AR_ADDR, 32'h1A00);
        #2 rst = 1'b0;
        #1;
        chk("t7_rreq_drop", R_req, 0);
        chk("t7_wreq", W_req, 0);
        chk("t7_do", DO, 0);
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) begin
                csr_rd(c, r, d);
                chk("t7_reg_zero", d, 0);
            end
        repeat (10) @(negedge clk);
        chk("t7_no_req", R_req | W_req, 0);

        chk("extra_beats", n_extra, 0);
        chk("req_overlap", n_overlap, 0);
        chk("addr_unstable", n_unstable, 0);
        chk("fetch_left", fq.size(), 0);
        chk("writes_left", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dma_mc.md
# dma_mc

Multi-channel descriptor-chained DMA engine, the parametrised successor to the single-channel DMA. It sits on the CPU's memory-mapped peripheral bus as a register slave and drives the shared read/write master port. NCH independent channels each walk their own linked descriptor list. Channels are served round-robin at descriptor granularity, with per-channel status, byte counters and maskable interrupts.

## Interface
- NCH, 2: number of channels, 1..8.
- DATA_W, 32: master data width, 32 or 64; BYTES = DATA_W/8.
- CSR_AW, clog2(NCH)+2: slave word-address width.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- DMA_interrupt  out  1  OR over channels of (DONE|ERR)&IE.
- R_req  out  1  read request, held until R_valid.
- AR_ADDR  out  32  read byte address.
- R_DATA  in  DATA_W  read data, sampled when R_valid=1.
- R_valid  in  1  one-cycle read completion pulse.
- W_req  out  1  write request, held until W_done.
- AW_ADDR  out  32  write byte address.
- W_DATA  out  DATA_W  write data.
- W_done  in  1  one-cycle write completion pulse.
- CEB  in  1  slave chip enable, active-low.
- WEB  in  1  slave write enable, active-low (0=write).
- A  in  CSR_AW  slave word address: {channel, reg[1:0]}.
- DI  in  32  slave write data.
- DO  out  32  slave read data, registered.

## Operation
- Per-channel registers, selected by reg index:
  - 0 CTRL: bit0 EN, bit1 IE.
  - 1 DESC_BASE.
  - 2 STATUS: bit0 BUSY (read-only), bit1 DONE (write-1-to-clear), bit2 ERR (write-1-to-clear).
  - 3 BYTES (read-only): bytes moved since the last start.
- Channel index >= NCH: reads return 0, writes are ignored.
- Start: a write of CTRL.EN 0->1 on an idle channel latches DESC_BASE into that channel's current pointer, sets BUSY, clears BYTES. Writes to DESC_BASE while BUSY are stored but take effect only at the next start.
- Descriptor layout is 4 words at ptr, fetched as 32-bit reads at ptr+0/4/8/12: SRC, DST, LEN (bytes), NEXT. NEXT[0]=EOC; the next pointer is {NEXT[31:2],2'b00}.
- Main FSM states:
  - IDLE: go to ARB if any channel has BUSY=1.
  - ARB: round-robin grant starting after the last-served channel.
  - DFETCH: 4 sequential reads.
  - CHECK, evaluated in this priority order:
    - SRC, DST or LEN not a multiple of BYTES -> ERR=1, EN=0, BUSY=0, then ARB.
    - LEN==0 -> skip to NEXTD.
    - Otherwise -> XRD.
  - XRD: read SRC+off.
  - XWR: write DST+off. On W_done: off += BYTES and BYTES += BYTES. Go to NEXTD if off==LEN, else XRD.
  - NEXTD:
    - EOC=1 -> DONE=1, EN=0, BUSY=0.
    - EOC=0 -> ptr = next pointer.
    - Either way, then ARB.
- Channels interleave per descriptor: after each descriptor the grant rotates even if the same channel still has work.
- EN cleared by software while BUSY: the current beat completes (XWR waits for W_done), then BUSY=0 with no DONE or ERR, and the FSM goes to ARB. The partial BYTES value remains readable.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. off and BYTES are 32-bit.
- STATUS conflict: a hardware set of DONE/ERR in the same cycle as a software W1C of that bit leaves the bit set.

## Timing
- Reset values: every output 0, all channel registers 0, FSM in IDLE, round-robin pointer at channel NCH-1 so channel 0 is granted first.
- Reset asserted mid-transfer drops R_req/W_req immediately.
- Slave port: write is effective at the clock edge where CEB=0 and WEB=0. Read: DO is valid the cycle after the edge with CEB=0 and WEB=1; DO holds its value otherwise.
- Master handshake:
  - R_req rises with a stable AR_ADDR and stays high until the R_valid cycle.
  - R_req deasserts the cycle after R_valid.
  - The next request is issued no earlier than one cycle after that.
  - W_req/AW_ADDR/W_DATA follow the same rules with W_done.
- R_req and W_req are never both high.
- Latency from EN write to the first R_req of DFETCH is at most 3 cycles when the engine is idle.
- DMA_interrupt is registered and rises 1 cycle after DONE or ERR sets, provided IE=1. It falls 1 cycle after the causing bit clears.

## Test plan
- Single descriptor, channel 0: SRC=0x1000, DST=0x2000, LEN=16, EOC=1, memory responds in 1 cycle. Required: 4 read/write beat pairs, memory at 0x2000..0x200C matches the source, BYTES=16, DONE=1, DMA_interrupt=1 with IE=1, EN=0.
- Two-link chain, LEN=8 then LEN=4, second has EOC: BYTES=12, DONE set only after the second descriptor.
- Two channels started in the same cycle, each with 2 descriptors: descriptor fetch order is ch0, ch1, ch0, ch1; both DONE; BYTES correct per channel.
- Error and skip:
  - LEN=6 with DATA_W=32 -> ERR=1, no data beats, interrupt raised.
  - LEN=0 with EOC=1 -> DONE=1 and BYTES=0.
- Abort and reset:
  - Clear EN after the 2nd write beat of LEN=32 -> transfer stops after the in-flight beat, BYTES=8, DONE=0.
  - Separately, assert rst mid-XRD -> R_req=0 immediately and all registers read 0.
